// File: rtl/png_sink_pkg.sv
// ============================================================================
// Module      : png_sink_pkg
// Description : Shared types and constants for the PNG pixel sink.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package png_sink_pkg;

  localparam logic [2:0] CT_GRAY  = 3'd0;
  localparam logic [2:0] CT_GRAYA = 3'd1;
  localparam logic [2:0] CT_RGB   = 3'd2;
  localparam logic [2:0] CT_RGBA  = 3'd3;
  localparam logic [2:0] CT_PLTE  = 3'd4;

  // FIFO entry layout: {sof, eol, eof, rgba[31:0]}
  localparam int ENTRY_W = 35;
  localparam int DATA_W  = 32;
  localparam int SOF_BIT = 34;
  localparam int EOL_BIT = 33;
  localparam int EOF_BIT = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } sink_state_t;

  // Expand any supported colortype to RGBA8888; unknown codes behave as RGBA.
  function automatic logic [DATA_W-1:0] normalise_pixel(
    input logic [2:0] ct,
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b,
    input logic [7:0] a
  );
    logic [DATA_W-1:0] px;
    case (ct)
      CT_GRAY:         px = {r, r, r, 8'hFF};
      CT_GRAYA:        px = {r, r, r, a};
      CT_RGB, CT_PLTE: px = {r, g, b, 8'hFF};
      default:         px = {r, g, b, a};
    endcase
    return px;
  endfunction

endpackage

`default_nettype wire

// File: rtl/png_sink_fifo.sv
// ============================================================================
// Module      : png_sink_fifo
// Description : Synchronous show-ahead FIFO; a write at full is accepted when
//               a read happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module png_sink_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_rd;
  logic             w_wr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd      = i_rd_en && !o_empty;
  assign w_wr      = i_wr_en && (!o_full || w_rd);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/png_pixel_sink.sv
// ============================================================================
// Module      : png_pixel_sink
// Description : Captures the PNG decoder header and pixel stream, converts to
//               RGBA8888 with sof/eol/eof tags and buffers behind ready/valid.
//               Optional statistics enabled by PNG_SINK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module png_pixel_sink
  import png_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        png_start,
  input  logic [2:0]  png_colortype,
  input  logic [13:0] png_width,
  input  logic [31:0] png_height,
  input  logic        png_valid,
  input  logic [7:0]  png_r,
  input  logic [7:0]  png_g,
  input  logic [7:0]  png_b,
  input  logic [7:0]  png_a,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic        frame_active,
  output logic        frame_done,
  output logic        overflow,
  output logic [31:0] pixel_count,
  output logic        size_err
);

  sink_state_t         r_state;
  logic [2:0]          r_ct;
  logic [13:0]         r_width_m1;
  logic [31:0]         r_height_m1;
  logic [13:0]         r_x;
  logic [31:0]         r_y;
  logic                r_wr_en;
  logic [ENTRY_W-1:0]  r_wr_entry;
  logic                r_frame_active;
  logic                r_frame_done;
  logic                r_overflow;

  logic                w_sof;
  logic                w_eol;
  logic                w_eof;
  logic [DATA_W-1:0]   w_pix;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;

  assign w_sof = (r_x == 14'd0) && (r_y == 32'd0);
  assign w_eol = (r_x == r_width_m1);
  assign w_eof = w_eol && (r_y == r_height_m1);
  assign w_pix = normalise_pixel(r_ct, png_r, png_g, png_b, png_a);

  // Input pixels are staged one cycle so tags and colour conversion are
  // registered before entering the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ct           <= CT_GRAY;
      r_width_m1     <= '0;
      r_height_m1    <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_wr_en        <= 1'b0;
      r_wr_entry     <= '0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      if (png_start) begin
        r_ct           <= png_colortype;
        r_width_m1     <= png_width - 14'd1;
        r_height_m1    <= png_height - 32'd1;
        r_x            <= '0;
        r_y            <= '0;
        r_frame_active <= 1'b1;
        r_state        <= (png_width == 14'd0 || png_height == 32'd0) ? ST_FLUSH : ST_ACTIVE;
      end else begin
        case (r_state)
          ST_ACTIVE: begin
            if (png_valid) begin
              r_wr_en    <= 1'b1;
              r_wr_entry <= {w_sof, w_eol, w_eof, w_pix};
              if (w_eof) begin
                r_state <= ST_FLUSH;
              end else if (w_eol) begin
                r_x <= '0;
                r_y <= r_y + 32'd1;
              end else begin
                r_x <= r_x + 14'd1;
              end
            end
          end
          ST_FLUSH: begin
            if (w_empty && !r_wr_en) begin
              r_frame_done   <= 1'b1;
              r_frame_active <= 1'b0;
              r_state        <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A drop only happens when full and no entry leaves in the same cycle.
  assign w_drop = r_wr_en && w_full && !(m_ready && !w_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (png_start) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  png_sink_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_wr_en),
    .i_wr_data (r_wr_entry),
    .i_rd_en   (m_ready),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign m_valid      = !w_empty;
  assign m_data       = m_valid ? w_head[DATA_W-1:0] : '0;
  assign m_sof        = m_valid && w_head[SOF_BIT];
  assign m_eol        = m_valid && w_head[EOL_BIT];
  assign m_eof        = m_valid && w_head[EOF_BIT];
  assign frame_active = r_frame_active;
  assign frame_done   = r_frame_done;
  assign overflow     = r_overflow;

`ifdef PNG_SINK_STATS_EN
  logic [31:0] r_pixel_count;
  logic        r_size_err;

  // Counts every pixel seen in ACTIVE, whether or not the FIFO kept it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel_count <= '0;
      r_size_err    <= 1'b0;
    end else if (png_start) begin
      r_pixel_count <= '0;
      r_size_err    <= (r_state == ST_ACTIVE);
    end else if (r_state == ST_ACTIVE && png_valid) begin
      r_pixel_count <= r_pixel_count + 32'd1;
    end
  end

  assign pixel_count = r_pixel_count;
  assign size_err    = r_size_err;
`else
  assign pixel_count = '0;
  assign size_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_png_pixel_sink.sv
// ============================================================================
// Module      : tb_png_pixel_sink
// Description : Self-checking bench for png_pixel_sink with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_png_pixel_sink;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        png_start;
  logic [2:0]  png_colortype;
  logic [13:0] png_width;
  logic [31:0] png_height;
  logic        png_valid;
  logic [7:0]  png_r, png_g, png_b, png_a;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_sof, m_eol, m_eof;
  logic        frame_active, frame_done, overflow, size_err;
  logic [31:0] pixel_count;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  png_pixel_sink #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .png_start(png_start), .png_colortype(png_colortype),
    .png_width(png_width), .png_height(png_height), .png_valid(png_valid),
    .png_r(png_r), .png_g(png_g), .png_b(png_b), .png_a(png_a),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .m_eol(m_eol), .m_eof(m_eof), .frame_active(frame_active),
    .frame_done(frame_done), .overflow(overflow), .pixel_count(pixel_count),
    .size_err(size_err)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  ent_t   mq[$];
  ent_t   got[$];
  ent_t   pend_e;
  bit     pend_v = 0;
  int     phase = 0;            // 0 idle, 1 receiving, 2 draining
  int     m_ct;
  longint m_w, m_h, m_k;
  bit     e_done = 0, e_act = 0, e_ovf = 0, e_se = 0;
  longint e_pc = 0;
  int     done_cyc = -100, last_hs = -100, start_edge = -100, n_done = 0;

  function automatic ent_t model_pixel(input int ct, input longint k, input longint w,
                                       input longint h, input logic [7:0] r, g, b, a);
    ent_t e;
    bit gray, apass;
    longint x, y;
    x = k % w;
    y = k / w;
    gray  = (ct == 0) || (ct == 1);
    apass = !((ct == 0) || (ct == 2) || (ct == 4));
    e.d   = {r, gray ? r : g, gray ? r : b, apass ? a : 8'hFF};
    e.sof = (k == 0);
    e.eol = (x == w - 1);
    e.eof = (x == w - 1) && (y == h - 1);
    return e;
  endfunction

  function automatic ent_t got_at(input int i);
    ent_t e;
    e = '0;
    if (i < got.size()) e = got[i];
    return e;
  endfunction

  // Compare process: checks every cycle, then predicts the next clock edge.
  initial forever begin
    int  qsz0;
    bit  had_pend;
    ent_t t;
    @(negedge clk);
    if (rst) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_sideband", {m_sof, m_eol, m_eof}, 0);
      chk("rst_frame_active", frame_active, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_pixel_count", pixel_count, 0);
      chk("rst_size_err", size_err, 0);
      mq.delete();
      pend_v = 0; phase = 0;
      e_done = 0; e_act = 0; e_ovf = 0; e_pc = 0; e_se = 0;
    end else begin
      chk("m_valid", m_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_data", m_data, mq[0].d);
        chk("m_sof", m_sof, mq[0].sof);
        chk("m_eol", m_eol, mq[0].eol);
        chk("m_eof", m_eof, mq[0].eof);
      end
      chk("frame_done", frame_done, e_done);
      chk("frame_active", frame_active, e_act);
      chk("overflow", overflow, e_ovf);
`ifdef PNG_SINK_STATS_EN
      chk("pixel_count", pixel_count, e_pc);
      chk("size_err", size_err, e_se);
`else
      chk("pixel_count", pixel_count, 0);
      chk("size_err", size_err, 0);
`endif
      if (frame_done) begin done_cyc = cyc; n_done++; end

      qsz0 = mq.size();
      had_pend = pend_v;
      if (qsz0 > 0 && m_ready) begin
        t.d = m_data; t.sof = m_sof; t.eol = m_eol; t.eof = m_eof;
        got.push_back(t);
        last_hs = cyc + 1;
        void'(mq.pop_front());
      end
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend_e);
        else e_ovf = 1;
      end
      pend_v = 0;
      e_done = 0;
      if (png_start) begin
        e_se = (phase == 1);
        e_ovf = 0;
        e_pc = 0;
        e_act = 1;
        m_ct = int'(png_colortype);
        m_w = longint'(png_width);
        m_h = longint'(png_height);
        m_k = 0;
        phase = (m_w == 0 || m_h == 0) ? 2 : 1;
        start_edge = cyc + 1;
      end else if (phase == 1 && png_valid) begin
        pend_e = model_pixel(m_ct, m_k, m_w, m_h, png_r, png_g, png_b, png_a);
        pend_v = 1;
        e_pc++;
        if (m_k == m_w * m_h - 1) phase = 2;
        m_k++;
      end else if (phase == 2 && qsz0 == 0 && !had_pend) begin
        e_done = 1;
        e_act = 0;
        phase = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [2:0] ct, input logic [13:0] w, input logic [31:0] h);
    png_start = 1; png_colortype = ct; png_width = w; png_height = h;
    step();
    png_start = 0;
  endtask

  task automatic send(input logic [7:0] r, g, b, a);
    png_valid = 1; png_r = r; png_g = g; png_b = b; png_a = a;
    step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    png_valid = 0;
    while ((frame_active || m_valid) && n < 400) begin step(); n++; end
    if (n >= 400) chk("idle_timeout", 1, 0);
    step(); step();
  endtask

  initial begin
    int nd0;
    rst = 1; png_start = 0; png_colortype = 0; png_width = 0; png_height = 0;
    png_valid = 0; png_r = 0; png_g = 0; png_b = 0; png_a = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("init_m_valid", m_valid, 0);
    chk("init_frame_active", frame_active, 0);

    // Pixels outside a frame are ignored.
    send(8'h11, 8'h22, 8'h33, 8'h44);
    png_valid = 0; step();
    chk("idle_valid_ignored", m_valid, 0);

    // 4x2 RGB, always ready.
    got.delete();
    start_frame(3'd2, 14'd4, 32'd2);
    for (int i = 0; i < 8; i++) send(8'(i), 8'(8'h10 + i), 8'(8'h20 + i), 8'h55);
    wait_idle();
    chk("rgb_count", got.size(), 8);
    chk("rgb_px0", got_at(0).d, 32'h001020FF);
    chk("rgb_sof0", got_at(0).sof, 1);
    chk("rgb_eol3", got_at(3).eol, 1);
    chk("rgb_px3", got_at(3).d, 32'h031323FF);
    chk("rgb_eof7", got_at(7).eof, 1);
    chk("rgb_px7", got_at(7).d, 32'h071727FF);
    chk("rgb_done_lat", done_cyc - last_hs, 1);

    // Colortype normalisation.
    got.delete();
    start_frame(3'd0, 14'd1, 32'd1); send(8'h40, 8'h77, 8'h99, 8'h12); wait_idle();
    start_frame(3'd1, 14'd1, 32'd1); send(8'h40, 8'h77, 8'h99, 8'h12); wait_idle();
    start_frame(3'd3, 14'd2, 32'd1);
    send(8'h11, 8'h22, 8'h33, 8'h44); send(8'h55, 8'h66, 8'h77, 8'h88); wait_idle();
    start_frame(3'd4, 14'd1, 32'd1); send(8'hAA, 8'hBB, 8'hCC, 8'hDD); wait_idle();
    start_frame(3'd7, 14'd1, 32'd1); send(8'hAA, 8'hBB, 8'hCC, 8'hDD); wait_idle();
    chk("gray", got_at(0).d, 32'h404040FF);
    chk("graya", got_at(1).d, 32'h40404012);
    chk("rgba", got_at(3).d, 32'h55667788);
    chk("rgba_eof", got_at(3).eof, 1);
    chk("plte", got_at(4).d, 32'hAABBCCFF);
    chk("ct7", got_at(5).d, 32'hAABBCCDD);

    // Overflow: 10x2 RGBA, 18 pixels stalled, pixels 16/17 dropped.
    got.delete();
    m_ready = 0;
    start_frame(3'd3, 14'd10, 32'd2);
    for (int i = 0; i < 18; i++) send(8'(i), 8'(i), 8'(i), 8'(i));
    png_valid = 0; step(); step();
    send(8'd18, 8'd18, 8'd18, 8'd18);
    m_ready = 1;
    send(8'd19, 8'd19, 8'd19, 8'd19);
    wait_idle();
    chk("ovf_count", got.size(), 18);
    chk("ovf_px15", got_at(15).d, 32'h0F0F0F0F);
    chk("ovf_eol9", got_at(9).eol, 1);
    chk("ovf_px18", got_at(16).d, 32'h12121212);
    chk("ovf_eof", got_at(17).eof, 1);
    chk("ovf_px19", got_at(17).d, 32'h13131313);
    chk("ovf_sticky", overflow, 1);

    // Restart mid-frame after 3 of 8 pixels.
    got.delete();
    nd0 = n_done;
    m_ready = 0;
    start_frame(3'd2, 14'd4, 32'd2);
    for (int i = 0; i < 3; i++) send(8'(i + 1), 8'h02, 8'h03, 8'h00);
    png_valid = 0;
    m_ready = 1;
    start_frame(3'd2, 14'd2, 32'd1);
    send(8'hA0, 8'hB0, 8'hC0, 8'h00); send(8'hA1, 8'hB1, 8'hC1, 8'h00);
    wait_idle();
    chk("restart_count", got.size(), 5);
    chk("restart_sof_old", got_at(0).sof, 1);
    chk("restart_sof_new", got_at(3).sof, 1);
    chk("restart_px_new", got_at(3).d, 32'hA0B0C0FF);
    chk("restart_eof", got_at(4).eof, 1);
    chk("restart_done_once", n_done - nd0, 1);
    chk("restart_ovf_cleared", overflow, 0);
`ifdef PNG_SINK_STATS_EN
    chk("restart_size_err", size_err, 1);
    chk("restart_pixel_count", pixel_count, 2);
`else
    chk("restart_size_err", size_err, 0);
`endif

    // Zero-size frames.
    got.delete();
    start_frame(3'd2, 14'd0, 32'd3); wait_idle();
    chk("zero_w_done_lat", done_cyc - start_edge, 1);
    start_frame(3'd2, 14'd5, 32'd0); wait_idle();
    chk("zero_h_done_lat", done_cyc - start_edge, 1);
    chk("zero_no_pixels", got.size(), 0);

    // Asynchronous reset during a frame with a non-empty FIFO.
    m_ready = 0;
    start_frame(3'd2, 14'd4, 32'd2);
    for (int i = 0; i < 3; i++) send(8'h21, 8'h22, 8'h23, 8'h00);
    png_valid = 0;
    chk("pre_rst_valid", m_valid, 1);
    @(posedge clk); #3 rst = 1;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_frame_active", frame_active, 0);
    @(posedge clk); #1 rst = 0;
    got.delete();
    m_ready = 1;
    start_frame(3'd2, 14'd2, 32'd1);
    send(8'h31, 8'h32, 8'h33, 8'h00); send(8'h41, 8'h42, 8'h43, 8'h00);
    wait_idle();
    chk("post_rst_count", got.size(), 2);
    chk("post_rst_sof", got_at(0).sof, 1);
    chk("post_rst_px", got_at(0).d, 32'h313233FF);
    chk("post_rst_eof", got_at(1).eof, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
